// File: rtl/frame_streamer_pkg.sv
// -----------------------------------------------------------------------------
// frame_streamer_pkg
// Shared types and constants for the frame streamer:
//   cap_state_t        - capture FSM states (C_IDLE, C_CAPTURE, C_HOLD)
//   tx_state_t         - transmit FSM states (T_IDLE .. T_CHK)
//   DEFAULT_SYNC_BYTE  - first byte of every frame on the wire
//   DEFAULT_SAMPLE_W   - default width of the signed DSP sample
//   csum_add()         - modulo-256 running checksum step
// -----------------------------------------------------------------------------
package frame_streamer_pkg;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
  localparam int         DEFAULT_SAMPLE_W  = 16;

  typedef enum logic [1:0] {
    C_IDLE    = 2'd0,
    C_CAPTURE = 2'd1,
    C_HOLD    = 2'd2
  } cap_state_t;

  typedef enum logic [2:0] {
    T_IDLE    = 3'd0,
    T_SYNC    = 3'd1,
    T_COUNT   = 3'd2,
    T_PAYLOAD = 3'd3,
    T_CHK     = 3'd4
  } tx_state_t;

  // Checksum accumulation wraps naturally at 8 bits.
  function automatic logic [7:0] csum_add(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/frame_streamer_if.sv
// -----------------------------------------------------------------------------
// frame_streamer_if
// Byte handshake toward the UART transmitter.
//   tx_byte  - byte offered to the transmitter
//   tx_valid - tx_byte is valid
//   tx_ready - transmitter accepts a byte this cycle
// master: the frame streamer; slave: the UART transmitter.
// -----------------------------------------------------------------------------
interface frame_streamer_if;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_byte, output tx_valid, input tx_ready);
  modport slave  (input tx_byte, input tx_valid, output tx_ready);
endinterface

// File: rtl/frame_bank.sv
// -----------------------------------------------------------------------------
// frame_bank
// Two banks of BUF_LEN bytes. One synchronous write port and one read port
// whose data is registered (one cycle after the address is presented).
// Contents are never reset.
//   clk        - clock
//   i_we       - write enable
//   i_wr_bank  - bank selected for the write
//   i_wr_addr  - byte index within the write bank
//   i_wr_data  - byte to store
//   i_rd_bank  - bank selected for the read
//   i_rd_addr  - byte index within the read bank
//   o_rd_data  - registered read data
// -----------------------------------------------------------------------------
module frame_bank #(
  parameter int BUF_LEN = 32,
  parameter int AW      = 5
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic          i_wr_bank,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [7:0]    i_wr_data,
  input  logic          i_rd_bank,
  input  logic [AW-1:0] i_rd_addr,
  output logic [7:0]    o_rd_data
);

  logic [7:0] r_mem [0:1][0:BUF_LEN-1];
  logic [7:0] r_rd_data;

  // Write port: one byte per enabled cycle.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_wr_bank][i_wr_addr] <= i_wr_data;
    end
  end

  // Read port: registered data, free-running every cycle.
  always_ff @(posedge clk) begin
    r_rd_data <= r_mem[i_rd_bank][i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/frame_streamer.sv
// -----------------------------------------------------------------------------
// frame_streamer
// Captures BUF_LEN signed DSP samples (top 8 bits each) into one bank of a
// ping-pong buffer while the other bank is streamed to a UART as
//   SYNC_BYTE, frame_count, payload[0..BUF_LEN-1], checksum
// Ports:
//   clk            - single clock
//   rst            - synchronous active-high reset
//   frame_start    - single-cycle request to capture one frame
//   sample_in      - signed DSP sample
//   sample_valid   - qualifies sample_in
//   capture_active - high while capturing (gates upstream DSP enable)
//   tx             - byte handshake toward the UART (master side)
//   frame_count    - frames fully transmitted, modulo 256
//   overrun        - sticky: a frame_start was dropped
// -----------------------------------------------------------------------------
module frame_streamer
  import frame_streamer_pkg::*;
#(
  parameter int         BUF_LEN   = 32,
  parameter int         SAMPLE_W  = DEFAULT_SAMPLE_W,
  parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       frame_start,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  input  logic                       sample_valid,
  output logic                       capture_active,
  frame_streamer_if.master           tx,
  output logic [7:0]                 frame_count,
  output logic                       overrun
);

  localparam int         AW        = (BUF_LEN > 1) ? $clog2(BUF_LEN) : 1;
  localparam logic [7:0] LAST_IDX  = 8'(BUF_LEN - 1);
  localparam logic [7:0] BUF_LEN_B = 8'(BUF_LEN);

  // Capture side
  cap_state_t r_cap_state;
  logic [7:0] r_wr_idx;
  logic       r_wr_bank;
  logic       r_capture_active;
  logic       r_overrun;

  // Transmit side
  tx_state_t  r_tx_state;
  logic [7:0] r_tx_byte;
  logic       r_tx_valid;
  logic [7:0] r_sum;
  logic [7:0] r_frame_count;
  logic [7:0] r_rd_ptr;  // index of the next payload byte to load into r_tx_byte

  logic       w_tx_idle;
  logic       w_xfer;
  logic       w_swap;
  logic       w_we;
  logic [7:0] w_sample_byte;
  logic [7:0] w_rd_ptr_next;
  logic [7:0] w_rd_idx;
  logic [7:0] w_rd_data;

  assign w_tx_idle     = (r_tx_state == T_IDLE);
  assign w_xfer        = r_tx_valid & tx.tx_ready;
  assign w_we          = (r_cap_state == C_CAPTURE) & sample_valid;
  assign w_sample_byte = 8'(sample_in >>> (SAMPLE_W - 8));

  // Bank swap: last sample written (or held frame pending) while TX is idle.
  always_comb begin
    w_swap = 1'b0;
    case (r_cap_state)
      C_CAPTURE: w_swap = sample_valid & (r_wr_idx == LAST_IDX) & w_tx_idle;
      C_HOLD:    w_swap = w_tx_idle;
      default:   w_swap = 1'b0;
    endcase
  end

  // Read pointer look-ahead: the RAM is addressed with the pointer's next
  // value, so its registered output always holds payload[r_rd_ptr] and the
  // following byte is ready the cycle after each transfer.
  always_comb begin
    w_rd_ptr_next = r_rd_ptr;
    case (r_tx_state)
      T_COUNT: begin
        if (w_xfer) begin
          w_rd_ptr_next = 8'd1;
        end else begin
          w_rd_ptr_next = r_rd_ptr;
        end
      end
      T_PAYLOAD: begin
        if (w_xfer && (r_rd_ptr != BUF_LEN_B)) begin
          w_rd_ptr_next = r_rd_ptr + 8'd1;
        end else begin
          w_rd_ptr_next = r_rd_ptr;
        end
      end
      T_CHK: begin
        if (w_xfer) begin
          w_rd_ptr_next = 8'd0;
        end else begin
          w_rd_ptr_next = r_rd_ptr;
        end
      end
      default: w_rd_ptr_next = r_rd_ptr;
    endcase
  end

  // Past the last payload byte the address is a don't-care; keep it in range.
  always_comb begin
    if (w_rd_ptr_next >= BUF_LEN_B) begin
      w_rd_idx = 8'd0;
    end else begin
      w_rd_idx = w_rd_ptr_next;
    end
  end

  frame_bank #(
    .BUF_LEN (BUF_LEN),
    .AW      (AW)
  ) u_bank (
    .clk       (clk),
    .i_we      (w_we),
    .i_wr_bank (r_wr_bank),
    .i_wr_addr (AW'(r_wr_idx)),
    .i_wr_data (w_sample_byte),
    .i_rd_bank (~r_wr_bank),
    .i_rd_addr (AW'(w_rd_idx)),
    .o_rd_data (w_rd_data)
  );

  // Capture FSM: fills the write bank, hands it over to TX on a swap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cap_state      <= C_IDLE;
      r_wr_idx         <= 8'd0;
      r_wr_bank        <= 1'b0;
      r_capture_active <= 1'b0;
      r_overrun        <= 1'b0;
    end else begin
      if (w_swap) begin
        r_wr_bank <= ~r_wr_bank;
      end
      case (r_cap_state)
        C_IDLE: begin
          if (frame_start) begin
            r_cap_state      <= C_CAPTURE;
            r_wr_idx         <= 8'd0;
            r_capture_active <= 1'b1;
          end
        end
        C_CAPTURE: begin
          if (frame_start) begin
            r_overrun <= 1'b1;
          end
          if (sample_valid) begin
            if (r_wr_idx == LAST_IDX) begin
              r_wr_idx         <= 8'd0;
              r_capture_active <= 1'b0;
              r_cap_state      <= w_tx_idle ? C_IDLE : C_HOLD;
            end else begin
              r_wr_idx <= r_wr_idx + 8'd1;
            end
          end
        end
        C_HOLD: begin
          if (frame_start) begin
            r_overrun <= 1'b1;
          end
          if (w_tx_idle) begin
            r_cap_state <= C_IDLE;
          end
        end
        default: begin
          r_cap_state      <= C_IDLE;
          r_wr_idx         <= 8'd0;
          r_capture_active <= 1'b0;
        end
      endcase
    end
  end

  // TX FSM: streams sync, count, payload and checksum from the read bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_state    <= T_IDLE;
      r_tx_byte     <= 8'h00;
      r_tx_valid    <= 1'b0;
      r_sum         <= 8'h00;
      r_frame_count <= 8'h00;
      r_rd_ptr      <= 8'd0;
    end else begin
      r_rd_ptr <= w_rd_ptr_next;
      case (r_tx_state)
        T_IDLE: begin
          if (w_swap) begin
            r_tx_state <= T_SYNC;
            r_tx_byte  <= SYNC_BYTE;
            r_tx_valid <= 1'b1;
            r_sum      <= 8'h00;
          end
        end
        T_SYNC: begin
          if (w_xfer) begin
            r_tx_state <= T_COUNT;
            r_tx_byte  <= r_frame_count;
          end
        end
        T_COUNT: begin
          if (w_xfer) begin
            r_tx_state <= T_PAYLOAD;
            r_tx_byte  <= w_rd_data;
            r_sum      <= w_rd_data;
          end
        end
        T_PAYLOAD: begin
          if (w_xfer) begin
            if (r_rd_ptr == BUF_LEN_B) begin
              r_tx_state <= T_CHK;
              r_tx_byte  <= r_sum;
            end else begin
              r_tx_byte <= w_rd_data;
              r_sum     <= csum_add(r_sum, w_rd_data);
            end
          end
        end
        T_CHK: begin
          if (w_xfer) begin
            r_tx_state    <= T_IDLE;
            r_tx_valid    <= 1'b0;
            r_tx_byte     <= 8'h00;
            r_frame_count <= r_frame_count + 8'd1;
          end
        end
        default: begin
          r_tx_state <= T_IDLE;
          r_tx_valid <= 1'b0;
          r_tx_byte  <= 8'h00;
        end
      endcase
    end
  end

  assign capture_active = r_capture_active;
  assign overrun        = r_overrun;
  assign frame_count    = r_frame_count;
  assign tx.tx_byte     = r_tx_byte;
  assign tx.tx_valid    = r_tx_valid;

endmodule

// File: doc/frame_streamer.md
FRAME_STREAMER -- requirements
Module: frame_streamer

Interface
REQ-001 Parameter BUF_LEN, default 32, SHALL set the number of samples per frame (range 2..255).
REQ-002 Parameter SAMPLE_W, default `BITS, SHALL set the width of the signed input sample.
REQ-003 Parameter SYNC_BYTE, default 8'hA5, SHALL set the first byte of every transmitted frame.
REQ-004 Port clk, input, 1, SHALL be the single clock; every port is synchronous to it.
REQ-005 Port rst, input, 1, SHALL be the reset: synchronous, active-high.
REQ-006 Port frame_start, input, 1, SHALL be the single-cycle request to begin capturing one frame.
REQ-007 Port sample_in, input, SAMPLE_W, SHALL carry the signed DSP sample.
REQ-008 Port sample_valid, input, 1, SHALL qualify sample_in.
REQ-009 Port capture_active, output, 1, SHALL be high while samples are being captured; it gates the upstream DSP enable.
REQ-010 Port tx_byte, output, 8, SHALL carry the byte offered to the UART transmitter.
REQ-011 Port tx_valid, output, 1, SHALL be high when tx_byte is valid.
REQ-012 Port tx_ready, input, 1, SHALL be high when the UART transmitter can accept a byte.
REQ-013 Port frame_count, output, 8, SHALL count fully transmitted frames, wrapping modulo 256.
REQ-014 Port overrun, output, 1, SHALL be a sticky flag for frame_start requests that were dropped.

Function
REQ-015 Storage SHALL be two banks of BUF_LEN bytes: one bank is written while the other is transmitted.
REQ-016 Each stored byte SHALL be sample_in arithmetically shifted right by SAMPLE_W-8 (top 8 bits, sign preserved).
REQ-017 Capture FSM states SHALL be C_IDLE, C_CAPTURE and C_HOLD.
REQ-018 C_IDLE + frame_start SHALL go to C_CAPTURE next cycle, with write index 0 and capture_active=1.
REQ-019 In C_CAPTURE, each sample_valid cycle SHALL write one byte at the write index and increment the index; cycles without sample_valid write nothing.
REQ-020 On the write at index BUF_LEN-1: if the TX FSM is in T_IDLE, the banks SHALL swap and capture SHALL return to C_IDLE; otherwise capture SHALL go to C_HOLD.
REQ-021 In C_HOLD, capture_active SHALL be 0; the swap SHALL happen on the first cycle TX is in T_IDLE, then capture SHALL go to C_IDLE.
REQ-022 frame_start in C_CAPTURE or C_HOLD SHALL be ignored and SHALL set overrun to 1.
REQ-023 A bank swap SHALL move TX from T_IDLE to T_SYNC on the next cycle.
REQ-024 TX FSM states SHALL be T_IDLE, T_SYNC, T_COUNT, T_PAYLOAD and T_CHK.
REQ-025 T_SYNC SHALL send SYNC_BYTE; T_COUNT SHALL send frame_count; T_PAYLOAD SHALL send read-bank bytes 0..BUF_LEN-1 in order; T_CHK SHALL send the 8-bit modulo-256 sum of the payload bytes.
REQ-026 A byte SHALL transfer only on a cycle with tx_valid=1 and tx_ready=1; tx_byte SHALL be held stable while tx_valid=1 and tx_ready=0.
REQ-027 tx_valid SHALL be 1 in every TX state except T_IDLE, giving back-to-back bytes when tx_ready stays high.
REQ-028 Bank read latency SHALL be hidden: the next payload byte SHALL be presented on the cycle after a transfer, with no gaps.
REQ-029 When the checksum byte transfers, TX SHALL go to T_IDLE and frame_count SHALL increment by 1 (255 wraps to 0).
REQ-030 A frame is BUF_LEN+3 bytes on the wire.

Reset
REQ-031 While rst=1: capture SHALL be C_IDLE, TX SHALL be T_IDLE, the write bank SHALL be bank 0, and all indices SHALL be 0.
REQ-032 While rst=1: capture_active, tx_valid, overrun and frame_count SHALL be 0, and tx_byte SHALL be 8'h00.
REQ-033 Bank contents SHALL NOT be reset.
REQ-034 rst mid-frame SHALL abort capture and transmission; the first frame after reset SHALL carry count 0.
REQ-035 overrun SHALL be cleared only by rst.

Structure
REQ-036 Package frame_streamer_pkg SHALL hold the capture and TX state enums and the default SYNC_BYTE constant.
REQ-037 Sub-module frame_bank SHALL implement the two-bank byte RAM, with a synchronous write port and a registered read port selected by bank bit.

Verification
REQ-038 Basic frame: BUF_LEN=4, frame_start, samples 0x7FFF, 0x8000, 0x0100, 0xFF00 (SAMPLE_W=16), tx_ready=1 -> bytes A5, 00, 7F, 80, 01, FF, FF, then frame_count=1.
REQ-039 Backpressure: tx_ready toggling every other cycle -> byte stream identical to REQ-038, and tx_byte stable while stalled.
REQ-040 Ping-pong: a second frame_start immediately after the first swap, tx_ready=1 -> capture overlaps TX, the second frame carries count 01, overrun=0.
REQ-041 Hold: tx_ready=0 held while a second frame completes -> capture enters C_HOLD and capture_active=0; releasing tx_ready sends both frames in order.
REQ-042 Overrun and reset: frame_start during C_CAPTURE -> overrun=1 and the frame is unaffected; rst mid-payload -> tx_valid=0 next cycle and the next frame carries count 00.
